// File: rtl/seq_mult16_if.sv
// seq_mult16_if: start/operand/result bundle between the operand stage and the multiplier
interface seq_mult16_if;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] p;
   modport master (output start, a, b, input busy, done, p);
   modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/seq_mult16.sv
// seq_mult16: 16x16 unsigned shift-and-add multiplier retiring one multiplier bit per clock
module rca16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        ci,
   output logic [15:0] s,
   output logic        co
);
   logic c;
   // ripple the carry bit by bit through the 16 full-adder stages
   always_comb begin
      c = ci;
      s = '0;
      for (int i = 0; i < 16; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      co = c;
   end
endmodule

module seq_mult16 (
   input logic         clk,
   input logic         rst,
   seq_mult16_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   state_t      state_q, state_d;
   logic [15:0] m_q, m_d, a_q, a_d, q_q, q_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] p_q, p_d;
   logic [15:0] sum, acc;
   logic        co, c_add;
   rca16 u_add (.x(a_q), .y(m_q), .ci(1'b0), .s(sum), .co(co));
   // the adder result is only kept when the current multiplier bit is set; its carry feeds the shift
   assign {c_add, acc} = q_q[0] ? {co, sum} : {1'b0, a_q};
   assign bus.busy = state_q == RUN;
   assign bus.done = state_q == DONE;
   assign bus.p    = p_q;
   // next-state and datapath update: capture on accept, add-and-shift while running
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      a_d     = a_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      case (state_q)
         IDLE: if (bus.start) begin
            m_d     = bus.a;
            q_d     = bus.b;
            a_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            a_d   = {c_add, acc[15:1]};
            q_d   = {acc[0], q_q[15:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
               state_d = DONE;
               p_d     = {c_add, acc[15:1], acc[0], q_q[15:1]};
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state register; reset clears everything including the product
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         a_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         a_q     <= a_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end
endmodule
